// File: rtl/sram_mrd_be.sv
// rtl/sram_mrd_be.sv - multi-read-port SRAM with per-byte active-low write enables
// Configurable read-during-write behaviour and optional array clear after reset.
module sram_mrd_be #(
  parameter int DEPTH          = 65536,
  parameter int DATA_WIDTH     = 32,
  parameter int NRD            = 2,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NB = DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cen,
  input  logic                      wen,
  input  logic [NB-1:0]             ben,
  input  logic [AW-1:0]             waddr,
  input  logic [DATA_WIDTH-1:0]     din,
  input  logic [NRD*AW-1:0]         raddr,
  output logic [NRD*DATA_WIDTH-1:0] dout,
  output logic                      ready
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // One extra bit so addresses at or above a non-power-of-two DEPTH compare correctly.
  localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t                  state_q;
  state_t                  state_d;
  logic [AW-1:0]           clr_cnt;
  logic                    clr_we;
  logic                    ready_q;
  logic                    waddr_ok;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  always_comb begin
    state_d = state_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (CLEAR_ON_RESET != 0) begin
          clr_we = 1'b1;
          if (clr_cnt == LAST) state_d = ST_READY;
        end else begin
          state_d = ST_READY;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      clr_cnt <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_READY);
      if (clr_we) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  assign ready    = ready_q;
  assign waddr_ok = ({1'b0, waddr} < DEPTH_X);
  assign wr_en    = (state_q == ST_READY) && !cen && !wen && waddr_ok;

  // Reset itself never touches the array; only clear cycles and user writes do.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[clr_cnt] <= '0;
      end else if (wr_en) begin
        for (int k = 0; k < NB; k++) begin
          if (!ben[k]) mem[waddr][8*k +: 8] <= din[8*k +: 8];
        end
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]         a;
    logic                  ok;
    logic                  hit;
    logic [DATA_WIDTH-1:0] old_w;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] q;

    assign a     = raddr[i*AW +: AW];
    assign ok    = ({1'b0, a} < DEPTH_X);
    assign hit   = (RDW_MODE != 0) && wr_en && (a == waddr);
    assign old_w = ok ? mem[a] : '0;

    // Write-through merges only the bytes being written into the old word.
    always_comb begin
      word = old_w;
      if (hit) begin
        for (int k = 0; k < NB; k++) begin
          if (!ben[k]) word[8*k +: 8] = din[8*k +: 8];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst || (state_q != ST_READY) || cen) q <= '0;
      else                                     q <= word;
    end

    assign dout[i*DATA_WIDTH +: DATA_WIDTH] = q;
  end

endmodule

// File: tb/tb_sram_mrd_be.sv
// tb/tb_sram_mrd_be.sv - directed self-checking bench for sram_mrd_be
// Three instances share stimulus: 16-deep old-data, 16-deep write-through, 12-deep old-data.
module tb_sram_mrd_be;

  logic        clk;
  logic        rst;
  logic        cen;
  logic        wen;
  logic [3:0]  ben;
  logic [3:0]  waddr;
  logic [31:0] din;
  logic [11:0] raddr;
  logic [95:0] d0, d1, d2;
  logic        r0, r1, r2;

  int total = 0;
  int bad   = 0;

  sram_mrd_be #(.DEPTH(16), .DATA_WIDTH(32), .NRD(3), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst(rst), .cen(cen), .wen(wen), .ben(ben), .waddr(waddr),
    .din(din), .raddr(raddr), .dout(d0), .ready(r0)
  );

  sram_mrd_be #(.DEPTH(16), .DATA_WIDTH(32), .NRD(3), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst(rst), .cen(cen), .wen(wen), .ben(ben), .waddr(waddr),
    .din(din), .raddr(raddr), .dout(d1), .ready(r1)
  );

  sram_mrd_be #(.DEPTH(12), .DATA_WIDTH(32), .NRD(3), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u2 (
    .clk(clk), .rst(rst), .cen(cen), .wen(wen), .ben(ben), .waddr(waddr),
    .din(din), .raddr(raddr), .dout(d2), .ready(r2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic check_ports(input string tag, input logic [95:0] d,
                             input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    check({tag, ".p0"}, d[31:0],  e0);
    check({tag, ".p1"}, d[63:32], e1);
    check({tag, ".p2"}, d[95:64], e2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] v, input logic [3:0] b);
    cen   = 1'b0;
    wen   = 1'b0;
    waddr = a;
    din   = v;
    ben   = b;
    tick();
    wen   = 1'b1;
    ben   = 4'hF;
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; wen = 1'b1; ben = 4'hF;
    waddr = '0; din = '0; raddr = '0;
    tick();
    tick();
    check("rst.ready0", {31'b0, r0}, 32'd0);
    check("rst.ready2", {31'b0, r2}, 32'd0);
    check_ports("rst.d0", d0, 32'h0, 32'h0, 32'h0);

    // Clear sequence with writes attempted to an already-cleared word while not ready.
    rst   = 1'b0;
    raddr = {4'd2, 4'd2, 4'd2};
    for (int e = 1; e <= 16; e++) begin
      cen = (e > 10);
      if (e >= 4 && e <= 10) begin
        wen = 1'b0; ben = 4'h0; waddr = 4'd2; din = 32'hFFFF_FFFF;
      end else begin
        wen = 1'b1; ben = 4'hF;
      end
      tick();
      check($sformatf("clr.ready0.e%0d", e), {31'b0, r0}, (e == 16) ? 32'd1 : 32'd0);
      check($sformatf("clr.ready1.e%0d", e), {31'b0, r1}, (e == 16) ? 32'd1 : 32'd0);
      check($sformatf("clr.ready2.e%0d", e), {31'b0, r2}, (e >= 12) ? 32'd1 : 32'd0);
      check($sformatf("clr.d0.e%0d", e), d0[31:0], 32'h0);
      check($sformatf("clr.d2.e%0d", e), d2[31:0], 32'h0);
    end
    wen = 1'b1; ben = 4'hF;

    cen   = 1'b0;
    raddr = {4'd15, 4'd7, 4'd0};
    tick();
    check_ports("zero.u0", d0, 32'h0, 32'h0, 32'h0);
    check_ports("zero.u1", d1, 32'h0, 32'h0, 32'h0);
    check_ports("zero.u2", d2, 32'h0, 32'h0, 32'h0);
    raddr = {4'd2, 4'd11, 4'd2};
    tick();
    check_ports("gate.u0", d0, 32'h0, 32'h0, 32'h0);
    check_ports("gate.u2", d2, 32'h0, 32'h0, 32'h0);

    // Byte-lane writes.
    wr(4'd3, 32'hAABB_CCDD, 4'b0000);
    wr(4'd3, 32'h1122_3344, 4'b1010);
    cen = 1'b0; raddr = {4'd0, 4'd0, 4'd3};
    tick();
    check("be.u0", d0[31:0], 32'hAA22_CC44);
    check("be.u1", d1[31:0], 32'hAA22_CC44);
    check("be.u2", d2[31:0], 32'hAA22_CC44);

    // Independent read ports.
    wr(4'd1, 32'h1, 4'b0000);
    wr(4'd2, 32'h2, 4'b0000);
    wr(4'd3, 32'h3, 4'b0000);
    raddr = {4'd3, 4'd2, 4'd1};
    tick();
    check_ports("mp.u0", d0, 32'h1, 32'h2, 32'h3);
    check_ports("mp.u2", d2, 32'h1, 32'h2, 32'h3);
    raddr = {4'd2, 4'd2, 4'd2};
    tick();
    check_ports("same.u1", d1, 32'h2, 32'h2, 32'h2);

    // Read during write on port 1.
    wr(4'd5, 32'hDEAD_BEEF, 4'b0000);
    cen = 1'b0; wen = 1'b0; waddr = 4'd5; din = 32'h1234_5678; ben = 4'b1100;
    raddr = {4'd0, 4'd5, 4'd0};
    tick();
    check("rdw.u0", d0[63:32], 32'hDEAD_BEEF);
    check("rdw.u1", d1[63:32], 32'hDEAD_5678);
    check("rdw.u2", d2[63:32], 32'hDEAD_BEEF);
    check("rdw.u1.p0", d1[31:0], 32'h0);
    wen = 1'b1; ben = 4'hF;
    tick();
    check("rdw.next.u0", d0[63:32], 32'hDEAD_5678);
    check("rdw.next.u1", d1[63:32], 32'hDEAD_5678);

    // Chip disabled: no write, outputs zero.
    cen = 1'b1; wen = 1'b0; ben = 4'h0; waddr = 4'd4; din = 32'hFFFF_FFFF;
    raddr = {4'd5, 4'd5, 4'd5};
    tick();
    check_ports("cen.u0", d0, 32'h0, 32'h0, 32'h0);
    check_ports("cen.u1", d1, 32'h0, 32'h0, 32'h0);
    cen = 1'b0; wen = 1'b1; ben = 4'hF; raddr = {4'd5, 4'd4, 4'd4};
    tick();
    check_ports("cen.after.u0", d0, 32'h0, 32'h0, 32'hDEAD_5678);
    check_ports("cen.after.u1", d1, 32'h0, 32'h0, 32'hDEAD_5678);

    // Out-of-range address on the 12-deep instance.
    wen = 1'b0; ben = 4'h0; waddr = 4'd13; din = 32'hFFFF_FFFF;
    raddr = {4'd13, 4'd13, 4'd13};
    tick();
    check_ports("oor.wr.u2", d2, 32'h0, 32'h0, 32'h0);
    check_ports("oor.wr.u0", d0, 32'h0, 32'h0, 32'h0);
    check_ports("oor.wr.u1", d1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wen = 1'b1; ben = 4'hF; raddr = {4'd13, 4'd1, 4'd11};
    tick();
    check_ports("oor.rd.u2", d2, 32'h0, 32'h1, 32'h0);
    check_ports("oor.rd.u0", d0, 32'h0, 32'h1, 32'hFFFF_FFFF);

    // Reset in the middle of a clear restarts it from address 0.
    rst = 1'b1; cen = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check($sformatf("mid.pre.ready0.e%0d", e), {31'b0, r0}, 32'd0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      check($sformatf("mid.ready0.e%0d", e), {31'b0, r0}, (e == 16) ? 32'd1 : 32'd0);
      check($sformatf("mid.ready2.e%0d", e), {31'b0, r2}, (e >= 12) ? 32'd1 : 32'd0);
    end
    cen = 1'b0; raddr = {4'd5, 4'd3, 4'd1};
    tick();
    check_ports("mid.zero.u0", d0, 32'h0, 32'h0, 32'h0);
    check_ports("mid.zero.u1", d1, 32'h0, 32'h0, 32'h0);
    check_ports("mid.zero.u2", d2, 32'h0, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
